// File: rtl/div4_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero bypasses the iteration and reports q=all ones, r=a, dz=1.
module div4_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam int unsigned RW = W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    r_q, r_d;
  logic            dz_q, dz_d;

  logic [RW-1:0]   rem_shift;
  logic [RW-1:0]   trial;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    // Partial remainder never exceeds b, so its top bit is shifted out harmlessly.
    rem_shift = RW'({rem_q, a_q[W-1]});
    trial     = rem_shift - {1'b0, b_q};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (b != '0) begin
            a_d     = a;
            b_d     = b;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(W - 1);
            state_d = S_CALC;
          end else begin
            q_d     = '1;
            r_d     = a;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        a_d   = {a_q[W-2:0], 1'b0};
        rem_d = trial[W] ? rem_shift : trial;
        quo_d = W'({quo_q, ~trial[W]});
        if (cnt_q == '0) begin
          q_d     = quo_d;
          r_d     = rem_d[W-1:0];
          dz_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div4_seq.sv
// Directed and random checks of div4_seq against arithmetic floor division,
// including cycle-accurate busy/done timing, hold, back-to-back and reset abort.
module tb_div4_seq;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;

  int checks;
  int errors;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_dz;

  div4_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start high for exactly one accepting edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb);
    start = 1'b1;
    a     = ta;
    b     = tb;
    tick();
    start = 1'b0;
  endtask

  // Called in the cycle right after the accepting edge; ends in the done cycle.
  task automatic expect_calc(input logic [W-1:0] ta, input logic [W-1:0] tb, input int poke);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    if (tb != '0) begin
      for (int i = 0; i < int'(W); i++) begin
        check("busy_calc", 32'(busy), 32'd1);
        check("done_calc", 32'(done), 32'd0);
        check("q_hold", 32'(q), 32'(prev_q));
        check("r_hold", 32'(r), 32'(prev_r));
        check("dz_hold", 32'(dz), 32'(prev_dz));
        if (i == poke) begin
          start = 1'b1;
          a     = W'(9);
          b     = W'(2);
        end else begin
          start = 1'b0;
        end
        tick();
      end
      start = 1'b0;
    end
    if (tb == '0) begin
      eq  = '1;
      er  = ta;
      edz = 1'b1;
    end else begin
      eq  = W'(int'(ta) / int'(tb));
      er  = W'(int'(ta) % int'(tb));
      edz = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("q", 32'(q), 32'(eq));
    check("r", 32'(r), 32'(er));
    check("dz", 32'(dz), 32'(edz));
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
  endtask

  task automatic go_idle();
    start = 1'b0;
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("q_idle", 32'(q), 32'(prev_q));
    check("r_idle", 32'(r), 32'(prev_r));
    check("dz_idle", 32'(dz), 32'(prev_dz));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    prev_q  = '0;
    prev_r  = '0;
    prev_dz = 1'b0;

    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);

    // Start on the first edge after reset release.
    rst = 1'b0;
    launch(W'(13), W'(3));
    expect_calc(W'(13), W'(3), -1);
    go_idle();

    // Back-to-back: start held through the done cycle.
    launch(W'(6), W'(3));
    expect_calc(W'(6), W'(3), -1);
    launch(W'(12), W'(5));
    expect_calc(W'(12), W'(5), -1);
    go_idle();

    launch(W'(5), W'(0));
    expect_calc(W'(5), W'(0), -1);
    go_idle();

    launch(W'(3), W'(12));
    expect_calc(W'(3), W'(12), -1);
    go_idle();
    launch(W'(15), W'(1));
    expect_calc(W'(15), W'(1), -1);
    go_idle();
    launch(W'(7), W'(7));
    expect_calc(W'(7), W'(7), -1);
    go_idle();

    // Start during the second calc cycle must be ignored.
    launch(W'(12), W'(5));
    expect_calc(W'(12), W'(5), 1);
    go_idle();

    // Reset in the third calc cycle aborts without a done pulse.
    launch(W'(13), W'(3));
    check("abort_busy1", 32'(busy), 32'd1);
    tick();
    tick();
    check("abort_busy3", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_dz", 32'(dz), 32'd0);
    prev_q  = '0;
    prev_r  = '0;
    prev_dz = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end
    launch(W'(13), W'(3));
    expect_calc(W'(13), W'(3), -1);
    go_idle();

    // Random operands, occasional zero divisor, random back-to-back chaining.
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      launch(ra, rb);
      expect_calc(ra, rb, -1);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
